execute_memory_latch: RTL and testbench

//  EX/MEM pipeline register of the 5-stage pipeline. Captures execute-stage results and the

---
 rtl/execute_memory_latch_if.sv | 68 ++++++
 rtl/execute_memory_latch.sv | 133 +++++++++++++
 tb/tb_execute_memory_latch.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/execute_memory_latch_if.sv
`default_nettype none
// ============================================================================
// Module : execute_memory_latch_if
// Brief  : EX/MEM latch bundle: execute-stage inputs, data-cache signals and
//          the registered MEM-stage outputs.
// Rev    : 1.0
// ============================================================================
interface execute_memory_latch_if #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
);
  logic              ihit;
  logic              stall;
  logic              flush;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;
  logic [WORD_W-1:0] alu_result_in;
  logic [WORD_W-1:0] rdat2_in;
  logic [WORD_W-1:0] pc4_in;
  logic [WORD_W-1:0] instr_in;
  logic [REG_AW-1:0] wsel_in;
  logic              dREN_in;
  logic              dWEN_in;
  logic              datomic_in;
  logic              MemtoReg_in;
  logic              RegWrite_in;
  logic              jal_in;
  logic              halt_in;

  logic [WORD_W-1:0] alu_result_out;
  logic [WORD_W-1:0] rdat2_out;
  logic [WORD_W-1:0] pc4_out;
  logic [WORD_W-1:0] instr_out;
  logic [REG_AW-1:0] wsel_out;
  logic              dREN_out;
  logic              dWEN_out;
  logic              datomic_out;
  logic              MemtoReg_out;
  logic              RegWrite_out;
  logic              jal_out;
  logic              halt_out;
  logic              dmemREN;
  logic              dmemWEN;
  logic              datomic;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic [WORD_W-1:0] load_data_out;
  logic              mem_busy;

  modport master (
    output ihit, stall, flush, dhit, dmemload,
    output alu_result_in, rdat2_in, pc4_in, instr_in, wsel_in,
    output dREN_in, dWEN_in, datomic_in, MemtoReg_in, RegWrite_in, jal_in, halt_in,
    input  alu_result_out, rdat2_out, pc4_out, instr_out, wsel_out,
    input  dREN_out, dWEN_out, datomic_out, MemtoReg_out, RegWrite_out, jal_out, halt_out,
    input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, load_data_out, mem_busy
  );

  modport slave (
    input  ihit, stall, flush, dhit, dmemload,
    input  alu_result_in, rdat2_in, pc4_in, instr_in, wsel_in,
    input  dREN_in, dWEN_in, datomic_in, MemtoReg_in, RegWrite_in, jal_in, halt_in,
    output alu_result_out, rdat2_out, pc4_out, instr_out, wsel_out,
    output dREN_out, dWEN_out, datomic_out, MemtoReg_out, RegWrite_out, jal_out, halt_out,
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, load_data_out, mem_busy
  );
endinterface
`default_nettype wire

// File: rtl/execute_memory_latch.sv
`default_nettype none
// ============================================================================
// Module : execute_memory_latch
// Brief  : EX/MEM pipeline register with a 3-state data-memory request FSM
//          that holds the request until dhit and never repeats an access.
// Rev    : 1.0
// ============================================================================
module execute_memory_latch #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  execute_memory_latch_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] rdat2;
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] instr;
    logic [REG_AW-1:0] wsel;
    logic              dren;
    logic              dwen;
    logic              datomic;
    logic              memtoreg;
    logic              regwrite;
    logic              jal;
    logic              halt;
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q;
  op_t               op_in;
  logic [WORD_W-1:0] held_q;
  logic              mem_busy;
  logic              advance;
  logic              pend_hit;
  logic              next_is_mem;
  logic              req_ren, req_wen, req_atomic;
  logic [WORD_W-1:0] load_data;

  assign op_in = '{
    alu_result: bus.alu_result_in,
    rdat2:      bus.rdat2_in,
    pc4:        bus.pc4_in,
    instr:      bus.instr_in,
    wsel:       bus.wsel_in,
    dren:       bus.dREN_in,
    dwen:       bus.dWEN_in,
    datomic:    bus.datomic_in,
    memtoreg:   bus.MemtoReg_in,
    regwrite:   bus.RegWrite_in,
    jal:        bus.jal_in,
    halt:       bus.halt_in
  };

  always_comb begin
    mem_busy    = (state_q == ST_PEND) && !bus.dhit;
    advance     = bus.ihit && !bus.stall && !mem_busy;
    pend_hit    = (state_q == ST_PEND) && bus.dhit;
    // A flushed slot is a bubble, so it never opens a memory access.
    next_is_mem = !bus.flush && (bus.dREN_in || bus.dWEN_in);
    state_d     = state_q;
    req_ren     = 1'b0;
    req_wen     = 1'b0;
    req_atomic  = 1'b0;
    load_data   = held_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (advance) state_d = next_is_mem ? ST_PEND : ST_IDLE;
      end
      ST_PEND: begin
        req_ren    = op_q.dren;
        req_wen    = op_q.dwen;
        req_atomic = op_q.datomic;
        load_data  = bus.dmemload;
        if (bus.dhit) begin
          if (advance) state_d = next_is_mem ? ST_PEND : ST_IDLE;
          else         state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q   <= '0;
      held_q <= '0;
    end else begin
      if (pend_hit) held_q <= bus.dmemload;
      if (advance) begin
        if (bus.flush) op_q <= '0;
        else           op_q <= op_in;
      end
    end
  end

  assign bus.alu_result_out = op_q.alu_result;
  assign bus.rdat2_out      = op_q.rdat2;
  assign bus.pc4_out        = op_q.pc4;
  assign bus.instr_out      = op_q.instr;
  assign bus.wsel_out       = op_q.wsel;
  assign bus.dREN_out       = op_q.dren;
  assign bus.dWEN_out       = op_q.dwen;
  assign bus.datomic_out    = op_q.datomic;
  assign bus.MemtoReg_out   = op_q.memtoreg;
  assign bus.RegWrite_out   = op_q.regwrite;
  assign bus.jal_out        = op_q.jal;
  assign bus.halt_out       = op_q.halt;
  assign bus.dmemREN        = req_ren;
  assign bus.dmemWEN        = req_wen;
  assign bus.datomic        = req_atomic;
  assign bus.dmemaddr       = op_q.alu_result;
  assign bus.dmemstore      = op_q.rdat2;
  assign bus.load_data_out  = load_data;
  assign bus.mem_busy       = mem_busy;

endmodule
`default_nettype wire

// File: tb/tb_execute_memory_latch.sv
`default_nettype none
// ============================================================================
// Module : tb_execute_memory_latch
// Brief  : Scoreboard bench for the EX/MEM latch: directed scenarios then
//          random traffic, compared against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_execute_memory_latch;
  localparam int WORD_W = 32;
  localparam int REG_AW = 5;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  execute_memory_latch_if #(.WORD_W(WORD_W), .REG_AW(REG_AW)) bus ();

  execute_memory_latch #(.WORD_W(WORD_W), .REG_AW(REG_AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdat2;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [4:0]  wsel;
    logic [6:0]  ctrl;   // {dren, dwen, atomic, memtoreg, regwrite, jal, halt}
  } op_t;

  typedef struct packed {
    logic        rst;
    logic        ihit;
    logic        stall;
    logic        flush;
    logic        dhit;
    logic [31:0] dmemload;
    op_t         op;
  } in_t;

  typedef struct packed {
    op_t         op;
    logic        ren;
    logic        wen;
    logic        atom;
    logic        busy;
    logic [31:0] load;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the op sitting in MEM, whether its access is still
  // outstanding, and the last word returned by the cache.
  op_t         m_op;
  logic        m_pend;
  logic [31:0] m_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input in_t x);
    exp_t e;
    logic adv;
    RST               = x.rst;
    bus.ihit          = x.ihit;
    bus.stall         = x.stall;
    bus.flush         = x.flush;
    bus.dhit          = x.dhit;
    bus.dmemload      = x.dmemload;
    bus.alu_result_in = x.op.alu;
    bus.rdat2_in      = x.op.rdat2;
    bus.pc4_in        = x.op.pc4;
    bus.instr_in      = x.op.instr;
    bus.wsel_in       = x.op.wsel;
    {bus.dREN_in, bus.dWEN_in, bus.datomic_in, bus.MemtoReg_in,
     bus.RegWrite_in, bus.jal_in, bus.halt_in} = x.op.ctrl;

    e.op   = m_op;
    e.busy = m_pend && !x.dhit;
    e.ren  = m_pend && m_op.ctrl[6];
    e.wen  = m_pend && m_op.ctrl[5];
    e.atom = m_pend && m_op.ctrl[4];
    e.load = m_pend ? x.dmemload : m_held;
    sb.push_back(e);

    if (x.rst) begin
      m_op   = '0;
      m_pend = 1'b0;
      m_held = '0;
    end else begin
      adv = x.ihit && !x.stall && !e.busy;
      if (m_pend && x.dhit) m_held = x.dmemload;
      if (adv) begin
        m_op   = x.flush ? '0 : x.op;
        m_pend = !x.flush && (x.op.ctrl[6] || x.op.ctrl[5]);
      end else if (x.dhit) begin
        m_pend = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic in_t nop();
    in_t r;
    r          = '0;
    r.ihit     = 1'b1;
    r.dmemload = $urandom;
    r.op.instr = $urandom;
    r.op.pc4   = $urandom;
    return r;
  endfunction

  function automatic in_t rnd();
    in_t r;
    r.rst      = ($urandom_range(0, 99) < 2);
    r.ihit     = ($urandom_range(0, 99) < 75);
    r.stall    = ($urandom_range(0, 99) < 20);
    r.flush    = ($urandom_range(0, 99) < 12);
    r.dhit     = ($urandom_range(0, 99) < 35);
    r.dmemload = $urandom;
    r.op.alu   = $urandom;
    r.op.rdat2 = $urandom;
    r.op.pc4   = $urandom;
    r.op.instr = $urandom;
    r.op.wsel  = 5'($urandom);
    r.op.ctrl  = 7'($urandom);
    r.op.ctrl[6] = ($urandom_range(0, 99) < 25);
    r.op.ctrl[5] = !r.op.ctrl[6] && ($urandom_range(0, 99) < 25);
    r.op.ctrl[4] = ($urandom_range(0, 99) < 10);
    return r;
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("alu_result_out", bus.alu_result_out, e.op.alu);
        check("rdat2_out",      bus.rdat2_out,      e.op.rdat2);
        check("pc4_out",        bus.pc4_out,        e.op.pc4);
        check("instr_out",      bus.instr_out,      e.op.instr);
        check("wsel_out",       32'(bus.wsel_out),  32'(e.op.wsel));
        check("ctrl_out", 32'({bus.dREN_out, bus.dWEN_out, bus.datomic_out, bus.MemtoReg_out,
                               bus.RegWrite_out, bus.jal_out, bus.halt_out}), 32'(e.op.ctrl));
        check("dmemaddr",       bus.dmemaddr,       e.op.alu);
        check("dmemstore",      bus.dmemstore,      e.op.rdat2);
        check("dmemREN",        32'(bus.dmemREN),   32'(e.ren));
        check("dmemWEN",        32'(bus.dmemWEN),   32'(e.wen));
        check("datomic",        32'(bus.datomic),   32'(e.atom));
        check("mem_busy",       32'(bus.mem_busy),  32'(e.busy));
        check("load_data_out",  bus.load_data_out,  e.load);
      end
    end
  end

  initial begin
    in_t x;
    in_t lw;
    in_t sw;

    // Reset with every input forced high.
    x = '1;
    cycle(x);
    m_op = '0; m_pend = 1'b0; m_held = '0;
    sb.delete();
    cycle(x);

    lw = nop();
    lw.op.alu = 32'h0000_0100; lw.op.ctrl = 7'b1001100; lw.op.wsel = 5'd8;
    sw = nop();
    sw.op.alu = 32'h0000_0200; sw.op.rdat2 = 32'h0000_1234; sw.op.ctrl = 7'b0100000;

    // Load with dhit on the third PEND cycle.
    cycle(lw);
    x = nop(); cycle(x);
    x = nop(); cycle(x);
    x = nop(); x.dhit = 1'b1; x.dmemload = 32'hDEAD_BEEF; cycle(x);
    x = nop(); cycle(x);

    // Store completing while fetch misses, then a long fetch miss.
    cycle(sw);
    x = nop(); x.ihit = 1'b0; x.dhit = 1'b1; cycle(x);
    for (int i = 0; i < 4; i++) begin
      x = nop(); x.ihit = 1'b0; x.dhit = 1'($urandom); cycle(x);
    end
    x = nop(); cycle(x);

    // Flush while the access is outstanding, then flush in IDLE.
    cycle(lw);
    x = nop(); x.flush = 1'b1; x.op = lw.op; cycle(x);
    x = nop(); x.flush = 1'b1; x.op = lw.op; x.dhit = 1'b1; x.dmemload = 32'hCAFE_0001; cycle(x);
    x = nop(); x.flush = 1'b1; x.op.ctrl = 7'b1000100; cycle(x);
    x = nop(); cycle(x);

    // Back-to-back load then store.
    cycle(lw);
    x = sw; x.dhit = 1'b1; x.dmemload = 32'h0BAD_F00D; cycle(x);
    x = nop(); cycle(x);
    x = nop(); x.dhit = 1'b1; cycle(x);
    x = nop(); cycle(x);

    // Reset in the middle of an access, followed by a late dhit.
    cycle(lw);
    x = nop(); cycle(x);
    x = nop(); x.rst = 1'b1; cycle(x);
    x = nop(); x.dhit = 1'b1; x.dmemload = 32'h5555_AAAA; cycle(x);
    x = nop(); cycle(x);

    for (int i = 0; i < 3000; i++) begin
      x = rnd();
      cycle(x);
    end

    @(negedge CLK);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
